// File: rtl/i2s_dsp_frame_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_dsp_frame_ctrl
//
// Master-mode DSP frame sequencer for the I2S RX path. Everything runs on the
// rising edge of the serial bit clock. The block produces the frame-sync (WS)
// pulse and the per-bit / per-slot timing that the DSP RX channel consumes.
// It counts slots and frames, inserts idle gaps between frames, and stops once
// a programmed frame budget has been used up. The channel enable is held high
// only while a whole frame is in progress, so only complete frames are captured.
//
// Parameters
//   MAX_GAP_W    width of the inter-frame gap configuration/counter
//   FRAME_CNT_W  width of the frame budget configuration/counter
//
// Ports
//   sck_i             in   serial bit clock (posedge)
//   rstn_i            in   asynchronous active-low reset
//   cfg_en_i          in   0->1 starts sequencing, 1->0 requests a graceful stop
//   cfg_num_bits_i    in   bits per word minus one
//   cfg_num_slots_i   in   words per frame minus one
//   cfg_frame_gap_i   in   idle sck cycles between frames (0 = back-to-back)
//   cfg_ws_len_i      in   0: one-cycle sync pulse, 1: sync high for all of slot 0
//   cfg_continuous_i  in   1: run until disabled, 0: stop after the frame budget
//   cfg_num_frames_i  in   frame budget minus one
//   ws_o              out  frame sync
//   ch_en_o           out  RX channel enable (FRAME state only)
//   slot_o            out  current slot index
//   bit_o             out  current bit index within the word
//   last_bit_o        out  current bit is the last bit of the word
//   frame_done_o      out  one-cycle pulse on the last bit of the last slot
//   busy_o            out  in FRAME or GAP
//   done_o            out  frame budget exhausted, held until cfg_en_i drops
// ---------------------------------------------------------------------------
module i2s_dsp_frame_ctrl #(
  parameter int MAX_GAP_W   = 9,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   sck_i,
  input  logic                   rstn_i,
  input  logic                   cfg_en_i,
  input  logic [4:0]             cfg_num_bits_i,
  input  logic [3:0]             cfg_num_slots_i,
  input  logic [MAX_GAP_W-1:0]   cfg_frame_gap_i,
  input  logic                   cfg_ws_len_i,
  input  logic                   cfg_continuous_i,
  input  logic [FRAME_CNT_W-1:0] cfg_num_frames_i,
  output logic                   ws_o,
  output logic                   ch_en_o,
  output logic [3:0]             slot_o,
  output logic [4:0]             bit_o,
  output logic                   last_bit_o,
  output logic                   frame_done_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [MAX_GAP_W-1:0]   GAP_ONE   = 1;
  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = 1;

  state_t                 state;

  // Configuration captured at every frame start
  logic [4:0]             num_bits_q;
  logic [3:0]             num_slots_q;
  logic [MAX_GAP_W-1:0]   gap_q;
  logic                   ws_len_q;
  logic                   continuous_q;
  logic [FRAME_CNT_W-1:0] num_frames_q;

  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [MAX_GAP_W-1:0]   gap_cnt;

  logic                   at_last;
  logic                   budget_hit;
  logic                   start_frame;
  logic [4:0]             adv_bit;
  logic [3:0]             adv_slot;
  logic                   adv_ws;
  logic                   adv_last;
  logic                   adv_done;
  logic                   start_last;
  logic                   start_done;

  // Outputs are registered, so the values for the *next* cycle are derived
  // here: the advanced bit/slot position inside a frame, and the first-cycle
  // values of a freshly started frame (which depend on the live cfg inputs
  // because they are latched on that same edge).
  always_comb begin
    at_last    = (bit_o == num_bits_q) && (slot_o == num_slots_q);
    budget_hit = !continuous_q && (frame_cnt == num_frames_q);

    if (bit_o == num_bits_q) begin
      adv_bit  = 5'd0;
      adv_slot = slot_o + 4'd1;
    end else begin
      adv_bit  = bit_o + 5'd1;
      adv_slot = slot_o;
    end

    adv_ws   = ws_len_q ? (adv_slot == 4'd0) : ((adv_slot == 4'd0) && (adv_bit == 5'd0));
    adv_last = (adv_bit == num_bits_q);
    adv_done = adv_last && (adv_slot == num_slots_q);

    start_last = (cfg_num_bits_i == 5'd0);
    start_done = start_last && (cfg_num_slots_i == 4'd0);

    // A new frame begins from IDLE, at the end of a gap, or directly after
    // the previous frame when no gap is configured.
    start_frame = 1'b0;
    case (state)
      ST_IDLE:  start_frame = cfg_en_i;
      ST_GAP:   start_frame = cfg_en_i && (gap_cnt == '0);
      ST_FRAME: start_frame = at_last && !budget_hit && cfg_en_i && (gap_q == '0);
      default:  start_frame = 1'b0;
    endcase
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= ST_IDLE;
      num_bits_q   <= '0;
      num_slots_q  <= '0;
      gap_q        <= '0;
      ws_len_q     <= 1'b0;
      continuous_q <= 1'b0;
      num_frames_q <= '0;
      frame_cnt    <= '0;
      gap_cnt      <= '0;
      ws_o         <= 1'b0;
      ch_en_o      <= 1'b0;
      slot_o       <= '0;
      bit_o        <= '0;
      last_bit_o   <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else if (start_frame) begin
      state        <= ST_FRAME;
      num_bits_q   <= cfg_num_bits_i;
      num_slots_q  <= cfg_num_slots_i;
      gap_q        <= cfg_frame_gap_i;
      ws_len_q     <= cfg_ws_len_i;
      continuous_q <= cfg_continuous_i;
      num_frames_q <= cfg_num_frames_i;
      gap_cnt      <= '0;
      ws_o         <= 1'b1;
      ch_en_o      <= 1'b1;
      slot_o       <= '0;
      bit_o        <= '0;
      last_bit_o   <= start_last;
      frame_done_o <= start_done;
      busy_o       <= 1'b1;
      done_o       <= 1'b0;
      // Coming out of GAP the count was already bumped when the frame ended.
      if (state == ST_FRAME) begin
        frame_cnt <= frame_cnt + FRAME_ONE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          frame_cnt <= '0;
        end

        ST_FRAME: begin
          if (at_last) begin
            ws_o         <= 1'b0;
            ch_en_o      <= 1'b0;
            slot_o       <= '0;
            bit_o        <= '0;
            last_bit_o   <= 1'b0;
            frame_done_o <= 1'b0;
            if (budget_hit) begin
              state     <= ST_DONE;
              frame_cnt <= frame_cnt + FRAME_ONE;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
            end else if (!cfg_en_i) begin
              state     <= ST_IDLE;
              frame_cnt <= '0;
              busy_o    <= 1'b0;
            end else begin
              // Counting down to zero gives exactly gap_q idle cycles.
              state     <= ST_GAP;
              frame_cnt <= frame_cnt + FRAME_ONE;
              gap_cnt   <= gap_q - GAP_ONE;
            end
          end else begin
            ws_o         <= adv_ws;
            bit_o        <= adv_bit;
            slot_o       <= adv_slot;
            last_bit_o   <= adv_last;
            frame_done_o <= adv_done;
          end
        end

        ST_GAP: begin
          if (!cfg_en_i) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            gap_cnt   <= '0;
            busy_o    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end

        ST_DONE: begin
          if (!cfg_en_i) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            done_o    <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_dsp_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2s_dsp_frame_ctrl
//
// Directed testbench for i2s_dsp_frame_ctrl. Inputs change and outputs are
// sampled on the falling edge of sck, half a period away from the active edge.
// The observed outputs are packed into one vector:
//   {ws, ch_en, busy, done, slot[3:0], bit[4:0], last_bit, frame_done}
// ---------------------------------------------------------------------------
module tb_i2s_dsp_frame_ctrl;

  logic       sck = 1'b0;
  logic       rstn;
  logic       cfg_en;
  logic [4:0] cfg_num_bits;
  logic [3:0] cfg_num_slots;
  logic [8:0] cfg_frame_gap;
  logic       cfg_ws_len;
  logic       cfg_continuous;
  logic [7:0] cfg_num_frames;
  logic       ws, ch_en, last_bit, frame_done, busy, done;
  logic [3:0] slot;
  logic [4:0] bitn;

  logic [14:0] obs_vec;
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [14:0] IDLE_VEC = 15'h0000;
  localparam logic [14:0] GAP_VEC  = 15'h1000;
  localparam logic [14:0] DONE_VEC = 15'h0800;

  always #5 sck = ~sck;

  i2s_dsp_frame_ctrl #(.MAX_GAP_W(9), .FRAME_CNT_W(8)) dut (
    .sck_i            (sck),
    .rstn_i           (rstn),
    .cfg_en_i         (cfg_en),
    .cfg_num_bits_i   (cfg_num_bits),
    .cfg_num_slots_i  (cfg_num_slots),
    .cfg_frame_gap_i  (cfg_frame_gap),
    .cfg_ws_len_i     (cfg_ws_len),
    .cfg_continuous_i (cfg_continuous),
    .cfg_num_frames_i (cfg_num_frames),
    .ws_o             (ws),
    .ch_en_o          (ch_en),
    .slot_o           (slot),
    .bit_o            (bitn),
    .last_bit_o       (last_bit),
    .frame_done_o     (frame_done),
    .busy_o           (busy),
    .done_o           (done)
  );

  assign obs_vec = {ws, ch_en, busy, done, slot, bitn, last_bit, frame_done};

  // Expected output vector for a cycle inside a frame
  function automatic logic [14:0] frame_vec(input logic w, input int s, input int b,
                                            input logic l, input logic f);
    return {w, 1'b1, 1'b1, 1'b0, 4'(s), 5'(b), l, f};
  endfunction

  task automatic set_cfg(input int nb, input int ns, input int gap, input logic wsl,
                         input logic cont, input int nf);
    cfg_num_bits   = 5'(nb);
    cfg_num_slots  = 4'(ns);
    cfg_frame_gap  = 9'(gap);
    cfg_ws_len     = wsl;
    cfg_continuous = cont;
    cfg_num_frames = 8'(nf);
  endtask

  // Drop enable and wait (bounded) for the sequencer to settle in IDLE
  task automatic go_idle(input string name);
    int waited = 0;
    cfg_en = 1'b0;
    @(negedge sck);
    while ((busy !== 1'b0 || done !== 1'b0) && waited < 100) begin
      @(negedge sck);
      waited++;
    end
    n_checks++;
    if (waited >= 100 || obs_vec !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL %s_return_idle: got %b expected %b", name, obs_vec, IDLE_VEC);
    end
  endtask

  task automatic test_reset;
    rstn   = 1'b0;
    cfg_en = 1'b0;
    set_cfg(7, 1, 0, 1'b0, 1'b1, 0);
    #23;
    n_checks++;
    if (obs_vec !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs_vec, IDLE_VEC);
    end
    @(negedge sck);
    rstn = 1'b1;
    @(negedge sck);
    @(negedge sck);
    n_checks++;
    if (obs_vec !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %b expected %b", obs_vec, IDLE_VEC);
    end
  endtask

  task automatic test_short_sync;
    logic [14:0] exp;
    int pos;
    set_cfg(7, 1, 0, 1'b0, 1'b1, 0);
    @(negedge sck);
    cfg_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge sck);
      pos = k % 16;
      exp = frame_vec(pos == 0, pos / 8, pos % 8, (pos % 8) == 7, pos == 15);
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL short_sync_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
    end
    go_idle("short_sync");
  endtask

  task automatic test_gap_long_ws;
    logic [14:0] exp;
    int pos;
    set_cfg(7, 1, 3, 1'b1, 1'b1, 0);
    @(negedge sck);
    cfg_en = 1'b1;
    for (int k = 0; k < 43; k++) begin
      @(negedge sck);
      pos = k % 19;
      if (pos < 16) exp = frame_vec((pos / 8) == 0, pos / 8, pos % 8, (pos % 8) == 7, pos == 15);
      else          exp = GAP_VEC;
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL gap_long_ws_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
    end
    go_idle("gap_long_ws");
  endtask

  task automatic test_frame_budget;
    logic [14:0] exp;
    int pos;
    int fd_count = 0;
    set_cfg(15, 0, 0, 1'b0, 1'b0, 2);
    @(negedge sck);
    cfg_en = 1'b1;
    for (int k = 0; k < 56; k++) begin
      @(negedge sck);
      pos = k % 16;
      if (k < 48) exp = frame_vec(pos == 0, 0, pos, pos == 15, pos == 15);
      else        exp = DONE_VEC;
      if (frame_done === 1'b1) fd_count++;
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL budget_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
    end
    n_checks++;
    if (fd_count != 3) begin
      n_fail++;
      $display("[TB] FAIL budget_frame_done_count: got %0d expected 3", fd_count);
    end
    cfg_en = 1'b0;
    @(negedge sck);
    n_checks++;
    if (obs_vec !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL budget_done_release: got %b expected %b", obs_vec, IDLE_VEC);
    end
  endtask

  task automatic test_graceful_stop;
    logic [14:0] exp;
    set_cfg(7, 1, 0, 1'b0, 1'b1, 0);
    @(negedge sck);
    cfg_en = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge sck);
      if (k < 16) exp = frame_vec(k == 0, k / 8, k % 8, (k % 8) == 7, k == 15);
      else        exp = IDLE_VEC;
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL graceful_stop_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
      if (k == 5) cfg_en = 1'b0;
    end
  endtask

  task automatic test_midframe_cfg;
    logic [14:0] exp;
    int pos;
    set_cfg(7, 1, 0, 1'b0, 1'b1, 0);
    @(negedge sck);
    cfg_en = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge sck);
      if (k < 16) begin
        exp = frame_vec(k == 0, k / 8, k % 8, (k % 8) == 7, k == 15);
      end else begin
        pos = (k - 16) % 32;
        exp = frame_vec(pos == 0, pos / 16, pos % 16, (pos % 16) == 15, pos == 31);
      end
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL midframe_cfg_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
      if (k == 3) cfg_num_bits = 5'd15;
    end
    go_idle("midframe_cfg");
  endtask

  task automatic test_reset_midframe;
    logic [14:0] exp;
    set_cfg(7, 1, 0, 1'b0, 1'b1, 0);
    @(negedge sck);
    cfg_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge sck);
      exp = frame_vec(k == 0, k / 8, k % 8, (k % 8) == 7, 1'b0);
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL pre_reset_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (obs_vec !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL async_reset_clear: got %b expected %b", obs_vec, IDLE_VEC);
    end
    @(negedge sck);
    n_checks++;
    if (obs_vec !== IDLE_VEC) begin
      n_fail++;
      $display("[TB] FAIL reset_held: got %b expected %b", obs_vec, IDLE_VEC);
    end
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge sck);
      exp = frame_vec(k == 0, k / 8, k % 8, (k % 8) == 7, 1'b0);
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL restart_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
    end
    go_idle("reset_midframe");
  endtask

  task automatic test_single_bit_words;
    logic [14:0] exp;
    int pos;
    set_cfg(0, 2, 1, 1'b1, 1'b1, 0);
    @(negedge sck);
    cfg_en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge sck);
      pos = k % 4;
      if (k >= 8)      exp = IDLE_VEC;
      else if (pos < 3) exp = frame_vec(pos == 0, pos, 0, 1'b1, pos == 2);
      else             exp = GAP_VEC;
      n_checks++;
      if (obs_vec !== exp) begin
        n_fail++;
        $display("[TB] FAIL single_bit_cycle%0d: got %b expected %b", k, obs_vec, exp);
      end
      if (k == 7) cfg_en = 1'b0;
    end
  endtask

  initial begin
    rstn   = 1'b0;
    cfg_en = 1'b0;
    test_reset;
    test_short_sync;
    test_gap_long_ws;
    test_frame_budget;
    test_graceful_stop;
    test_midframe_cfg;
    test_reset_midframe;
    test_single_bit_words;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
